// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared constants for the sequential divider.
// Holds the FSM state encoding and the iteration-counter width helper.
// No ports; imported by div_seq.
package div_seq_pkg;

  // FSM state encoding (legacy-compatible 2-bit constants)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter must hold DATA_WIDTH itself, hence one bit beyond clog2.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: request/result bundle of the sequential divider.
// master drives start/a/b and observes busy/done/results; slave is the divider.
// start is only honoured while the divider is idle (no other backpressure).
interface div_seq_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  start;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_seq_step.sv
// div_step: one combinational restoring-division step.
// Ports: rem (partial remainder), din (next dividend bit), divisor -> rem_nxt, qbit.
// Zero latency, no handshake; reusable in an unrolled or pipelined divider.
module div_step #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic                  din,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_nxt,
  output logic                  qbit
);
  // The shifted remainder {rem, din} is DATA_WIDTH+1 bits. Its top bit is
  // rem[MSB]; the low DATA_WIDTH bits go through a borrow-capturing subtract.
  logic [DATA_WIDTH-1:0] lo;
  logic [DATA_WIDTH-1:0] diff;
  logic                  borrow;

  assign lo = {rem[DATA_WIDTH-2:0], din};
  assign {borrow, diff} = {1'b0, lo} - {1'b0, divisor};

  // Trial is non-negative if the shifted value overflowed DATA_WIDTH bits
  // (then it certainly exceeds the divisor) or the low subtract did not borrow.
  // In both cases the new remainder is the low DATA_WIDTH bits of the trial.
  assign qbit    = rem[DATA_WIDTH-1] | ~borrow;
  assign rem_nxt = qbit ? diff : lo;
endmodule

// File: rtl/div_seq.sv
// div_seq: sequential unsigned divider, restoring, one quotient bit per cycle.
// Ports: clk, rst (async active-high), bus (div_seq_if.slave: start/a/b in,
// busy/done/quotient/remainder/div_by_zero out). Latency DATA_WIDTH+1 cycles
// from the start edge to done; start ignored unless idle, one division per DATA_WIDTH+2 cycles.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);
  localparam int CW = cnt_width(DATA_WIDTH);

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] rem_r;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] dvsr;
  logic                  busy_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] quot_r;
  logic [DATA_WIDTH-1:0] remd_r;
  logic                  dbz_r;

  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_q;
  logic [DATA_WIDTH-1:0] shreg_nxt;

  div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .rem     (rem_r),
    .din     (shreg[DATA_WIDTH-1]),
    .divisor (dvsr),
    .rem_nxt (step_rem),
    .qbit    (step_q)
  );

  // shreg consumes dividend bits from the top and collects quotient bits at
  // the bottom; after DATA_WIDTH steps it holds the whole quotient.
  assign shreg_nxt = {shreg[DATA_WIDTH-2:0], step_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      rem_r  <= '0;
      shreg  <= '0;
      dvsr   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      quot_r <= '0;
      remd_r <= '0;
      dbz_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            dvsr   <= bus.b;
            shreg  <= bus.a;
            rem_r  <= '0;
            cnt    <= CW'(DATA_WIDTH);
            busy_r <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          rem_r <= step_rem;
          shreg <= shreg_nxt;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            // Results are loaded on the final step so they are valid in
            // the cycle done is high.
            quot_r <= shreg_nxt;
            remd_r <= step_rem;
            dbz_r  <= (dvsr == '0);
            done_r <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = remd_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and randomized checks of div_seq at DATA_WIDTH = 4.
// Expected results come from plain integer division with the divide-by-zero rule.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_div_seq;
  localparam int W   = 4;
  localparam int LAT = W + 1;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  div_seq_if #(.DATA_WIDTH(W)) bus ();

  div_seq #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: a / b and a % b; divide by zero gives all ones and a.
  function automatic logic [W-1:0] ref_q(input int a, input int b);
    return (b == 0) ? W'((1 << W) - 1) : W'(a / b);
  endfunction

  function automatic logic [W-1:0] ref_r(input int a, input int b);
    return (b == 0) ? W'(a) : W'(a % b);
  endfunction

  // One isolated division: checks latency, busy span, results, and the
  // single-cycle done pulse.
  task automatic run_div(input int ta, input int tb_, input string tag);
    int k;
    int busy_n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = W'(ta);
    bus.b     = W'(tb_);
    @(negedge clk);
    bus.start = 1'b0;
    k      = 1;
    busy_n = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      if (bus.busy === 1'b1) busy_n++;
      @(negedge clk);
      k++;
    end
    if (bus.busy === 1'b1) busy_n++;
    chk({tag, "_lat"},  k, LAT);
    chk({tag, "_busy"}, busy_n, LAT);
    chk({tag, "_q"},    bus.quotient, ref_q(ta, tb_));
    chk({tag, "_r"},    bus.remainder, ref_r(ta, tb_));
    chk({tag, "_dbz"},  bus.div_by_zero, (tb_ == 0) ? 1 : 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, bus.done, 0);
    chk({tag, "_busy_fall"},  bus.busy, 0);
  endtask

  initial begin
    int k;
    int ndone;
    int ra;
    int rb;
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_q",    bus.quotient, 0);
    chk("rst_r",    bus.remainder, 0);
    chk("rst_dbz",  bus.div_by_zero, 0);
    rst = 1'b0;

    // 1: basic division
    run_div(13, 3, "t1");

    // 2: back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'd2;
    bus.b     = 4'd5;
    k = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t2a_lat", k, LAT);
    chk("t2a_q", bus.quotient, 0);
    chk("t2a_r", bus.remainder, 2);
    bus.a = 4'd15;
    bus.b = 4'd1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.done !== 1'b1 && k < 20);
    bus.start = 1'b0;
    chk("t2_gap", k, W + 2);
    chk("t2b_q", bus.quotient, 15);
    chk("t2b_r", bus.remainder, 0);
    @(negedge clk);

    // 3: divide by zero, then a normal division clears the flag
    run_div(9, 0, "t3a");
    run_div(8, 2, "t3b");

    // 4: start pulsed while running is ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'd12;
    bus.b     = 4'd4;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    ndone = 0;
    for (int c = 2; c < LAT + 8; c++) begin
      @(negedge clk);
      if (c == 2) begin
        bus.start = 1'b1;
        bus.a     = 4'd7;
        bus.b     = 4'd7;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        ndone++;
        k = c;
      end
    end
    chk("t4_ndone", ndone, 1);
    chk("t4_lat", k, LAT);
    chk("t4_q_hold", bus.quotient, 3);
    chk("t4_r_hold", bus.remainder, 0);
    chk("t4_busy", bus.busy, 0);

    // 5: asynchronous reset mid-run
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'd14;
    bus.b     = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy_clr", bus.busy, 0);
    chk("t5_done_clr", bus.done, 0);
    chk("t5_q_clr",    bus.quotient, 0);
    chk("t5_r_clr",    bus.remainder, 0);
    chk("t5_dbz_clr",  bus.div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("t5_no_done", ndone, 0);
    run_div(14, 3, "t5b");

    // 6: exhaustive sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_div(ia, ib, "t6");
      end
    end

    // Randomized operands with random idle gaps
    for (int n = 0; n < 40; n++) begin
      ra = int'($urandom_range(15, 0));
      rb = int'($urandom_range(15, 0));
      repeat ($urandom_range(3, 0)) @(negedge clk);
      run_div(ra, rb, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
